// File: rtl/rename_map_table_pkg.sv
// rtl/rename_map_table_pkg.sv - shared sizes, map types and CDB helpers for the rename map table
//
// Purpose: types shared by rename_map_table and map_ckpt_store.
//   PREG      : one map entry {reg_num, ready}
//   MAP_T     : a whole map, one PREG per architectural register
//   CKPT_IDX  : checkpoint slot index
//   cdb_hit   : does a physical tag match any valid CDB broadcast
//   cdb_apply : mark every matching map entry ready, except entries in skip
package rename_map_table_pkg;
  localparam int ARCH_REGS    = 32;
  localparam int PHYS_REGS    = 64;
  localparam int RENAME_WIDTH = 2;
  localparam int CDB_WIDTH    = 2;
  localparam int RETIRE_WIDTH = 2;
  localparam int NUM_CKPT     = 4;
  localparam int PW           = $clog2(PHYS_REGS);
  localparam int CW           = $clog2(NUM_CKPT);
  localparam int REG_SZ       = $clog2(ARCH_REGS);
  localparam int PHYS_REG_SZ  = PW;

  typedef struct packed {
    logic [PHYS_REG_SZ-1:0] reg_num;
    logic                   ready;
  } PREG;

  typedef PREG [ARCH_REGS-1:0] MAP_T;
  typedef logic [CW-1:0] CKPT_IDX;

  localparam PREG ZERO_REG = '{reg_num: '0, ready: 1'b1};
  localparam logic [CW:0] CKPT_FULL_CNT = (CW+1)'(NUM_CKPT);

  function automatic logic cdb_hit(input logic [PW-1:0] pr,
                                   input logic [CDB_WIDTH-1:0] v,
                                   input logic [CDB_WIDTH-1:0][PW-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CDB_WIDTH; i++)
      if (v[i] && tags[i] == pr) hit = 1'b1;
    return hit;
  endfunction

  function automatic MAP_T cdb_apply(input MAP_T m,
                                     input logic [ARCH_REGS-1:0] skip,
                                     input logic [CDB_WIDTH-1:0] v,
                                     input logic [CDB_WIDTH-1:0][PW-1:0] tags);
    MAP_T r;
    r = m;
    for (int a = 0; a < ARCH_REGS; a++)
      if (!skip[a] && cdb_hit(m[a].reg_num, v, tags)) r[a].ready = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rename_map_table_map_ckpt_store.sv
// rtl/rename_map_table_map_ckpt_store.sv - FIFO ring of branch checkpoints of the speculative map
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   push, snap_map        : store snap_map at tail (caller guarantees not full)
//   pop                   : free the head slot (caller guarantees not empty)
//   restore, restore_id   : drop everything younger than restore_id, keeping it
//   flush                 : free all slots
//   cdb_valid, cdb_pr     : ready broadcasts applied to every stored entry
//   rd_map                : slot restore_id, before this cycle's CDB update
//   tail, count           : next slot to be written, number of live slots
module map_ckpt_store
  import rename_map_table_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           restore,
  input  CKPT_IDX                        restore_id,
  input  logic                           flush,
  input  MAP_T                           snap_map,
  input  logic [CDB_WIDTH-1:0]           cdb_valid,
  input  logic [CDB_WIDTH-1:0][PW-1:0]   cdb_pr,
  output MAP_T                           rd_map,
  output CKPT_IDX                        tail,
  output logic [CW:0]                    count
);
  MAP_T        ring [NUM_CKPT];
  CKPT_IDX     head_q;
  CKPT_IDX     tail_q;
  logic [CW:0] count_q;

  assign rd_map = ring[restore_id];
  assign tail   = tail_q;
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_CKPT; i++) ring[i] <= '0;
    end else begin
      // Free slots are updated too; harmless, and keeps the update uniform.
      for (int i = 0; i < NUM_CKPT; i++)
        ring[i] <= cdb_apply(ring[i], '0, cdb_valid, cdb_pr);
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop) head_q <= head_q + CKPT_IDX'(1);
        if (restore) begin
          // Restored slot stays live: count is its distance from head plus one.
          tail_q  <= restore_id + CKPT_IDX'(1);
          count_q <= {1'b0, CKPT_IDX'(restore_id - head_q)} + (CW+1)'(1)
                     - {{CW{1'b0}}, pop};
        end else begin
          if (push) begin
            ring[tail_q] <= snap_map;  // snap_map already carries this cycle's CDB
            tail_q       <= tail_q + CKPT_IDX'(1);
          end
          count_q <= count_q + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
        end
      end
    end
  end
endmodule

// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - multi-way register rename map with CDB update, retire and checkpoints
//
// Ports:
//   clk, reset_n                          : clock, asynchronous active-low reset
//   rn_valid/rn_rs1/rn_rs2/rn_rd/rn_new_pr: rename group, slot 0 oldest
//   rn_rs1_pr/rn_rs2_pr/rn_old_pr         : looked-up mappings with bypass and CDB forwarding
//   ckpt_take/ckpt_id/ckpt_full           : snapshot request, slot it uses, ring full
//   ckpt_release                          : free oldest checkpoint
//   ckpt_restore/ckpt_restore_id          : mispredict restore
//   flush                                 : reload speculative map from architectural map
//   cdb_valid/cdb_pr                      : ready broadcasts
//   rt_valid/rt_rd/rt_pr                  : retire ports, highest slot wins
//   arch_map_out                          : architectural map
module rename_map_table
  import rename_map_table_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [RENAME_WIDTH-1:0]              rn_valid,
  input  logic [RENAME_WIDTH-1:0][REG_SZ-1:0]  rn_rs1,
  input  logic [RENAME_WIDTH-1:0][REG_SZ-1:0]  rn_rs2,
  input  logic [RENAME_WIDTH-1:0][REG_SZ-1:0]  rn_rd,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]      rn_new_pr,
  output PREG  [RENAME_WIDTH-1:0]              rn_rs1_pr,
  output PREG  [RENAME_WIDTH-1:0]              rn_rs2_pr,
  output PREG  [RENAME_WIDTH-1:0]              rn_old_pr,
  input  logic                                 ckpt_take,
  output CKPT_IDX                              ckpt_id,
  output logic                                 ckpt_full,
  input  logic                                 ckpt_release,
  input  logic                                 ckpt_restore,
  input  CKPT_IDX                              ckpt_restore_id,
  input  logic                                 flush,
  input  logic [CDB_WIDTH-1:0]                 cdb_valid,
  input  logic [CDB_WIDTH-1:0][PW-1:0]         cdb_pr,
  input  logic [RETIRE_WIDTH-1:0]              rt_valid,
  input  logic [RETIRE_WIDTH-1:0][REG_SZ-1:0]  rt_rd,
  input  logic [RETIRE_WIDTH-1:0][PW-1:0]      rt_pr,
  output MAP_T                                 arch_map_out
);
  MAP_T                 spec_map;
  MAP_T                 arch_map;
  MAP_T                 ren_map;
  MAP_T                 arch_next;
  MAP_T                 spec_next;
  MAP_T                 ckpt_rd_map;
  logic [ARCH_REGS-1:0] written;
  logic [CW:0]          ckpt_count;
  logic                 do_take;
  logic                 do_pop;
  logic                 do_restore;

  assign ckpt_full    = (ckpt_count == CKPT_FULL_CNT);
  assign do_take      = ckpt_take && !ckpt_full && !ckpt_restore && !flush;
  assign do_pop       = ckpt_release && (ckpt_count != '0) && !flush;
  assign do_restore   = ckpt_restore && !flush;
  assign arch_map_out = arch_map;

  // Youngest older slot writing src wins; only non-bypassed values see the CDB.
  function automatic PREG lookup(input logic [REG_SZ-1:0] src, input int k);
    PREG  r;
    logic byp;
    r   = spec_map[src];
    byp = 1'b0;
    for (int j = 0; j < RENAME_WIDTH; j++)
      if (j < k && rn_valid[j] && rn_rd[j] == src) begin
        r   = '{reg_num: rn_new_pr[j], ready: 1'b0};
        byp = 1'b1;
      end
    if (!byp && cdb_hit(r.reg_num, cdb_valid, cdb_pr)) r.ready = 1'b1;
    if (src == '0) r = ZERO_REG;
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      rn_rs1_pr[k] = lookup(rn_rs1[k], k);
      rn_rs2_pr[k] = lookup(rn_rs2[k], k);
      rn_old_pr[k] = lookup(rn_rd[k], k);
    end
  end

  always_comb begin
    ren_map = spec_map;
    written = '0;
    for (int k = 0; k < RENAME_WIDTH; k++)
      if (rn_valid[k] && rn_rd[k] != '0) begin
        ren_map[rn_rd[k]] = '{reg_num: rn_new_pr[k], ready: 1'b0};
        written[rn_rd[k]] = 1'b1;
      end
    // Freshly renamed entries are skipped: a same-cycle tag must not mark them ready.
    ren_map = cdb_apply(ren_map, written, cdb_valid, cdb_pr);

    arch_next = arch_map;
    for (int r = 0; r < RETIRE_WIDTH; r++)
      if (rt_valid[r] && rt_rd[r] != '0)
        arch_next[rt_rd[r]] = '{reg_num: rt_pr[r], ready: 1'b1};

    if (flush) begin
      spec_next = arch_next;
      for (int a = 0; a < ARCH_REGS; a++) spec_next[a].ready = 1'b1;
    end else if (ckpt_restore) begin
      spec_next = cdb_apply(ckpt_rd_map, '0, cdb_valid, cdb_pr);
    end else begin
      spec_next = ren_map;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= '{reg_num: PW'(i), ready: 1'b1};
        arch_map[i] <= '{reg_num: PW'(i), ready: 1'b1};
      end
    end else begin
      spec_map <= spec_next;
      arch_map <= arch_next;
    end
  end

  map_ckpt_store u_ckpt (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (do_take),
    .pop        (do_pop),
    .restore    (do_restore),
    .restore_id (ckpt_restore_id),
    .flush      (flush),
    .snap_map   (ren_map),
    .cdb_valid  (cdb_valid),
    .cdb_pr     (cdb_pr),
    .rd_map     (ckpt_rd_map),
    .tail       (ckpt_id),
    .count      (ckpt_count)
  );
endmodule

// File: tb/tb_rename_map_table.sv
// tb/tb_rename_map_table.sv - scoreboard bench for rename_map_table, directed plus random
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  typedef struct { int pr; bit rdy; } ment_t;
  typedef struct packed {
    logic [2:0][RENAME_WIDTH-1:0][6:0] lk;
    logic [1:0]                        ckid;
    logic                              full;
    logic [ARCH_REGS-1:0][6:0]         arch;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [RENAME_WIDTH-1:0]             rn_valid;
  logic [RENAME_WIDTH-1:0][4:0]        rn_rs1, rn_rs2, rn_rd;
  logic [RENAME_WIDTH-1:0][5:0]        rn_new_pr;
  PREG  [RENAME_WIDTH-1:0]             rn_rs1_pr, rn_rs2_pr, rn_old_pr;
  logic                                ckpt_take, ckpt_full, ckpt_release, ckpt_restore, flush;
  CKPT_IDX                             ckpt_id, ckpt_restore_id;
  logic [CDB_WIDTH-1:0]                cdb_valid;
  logic [CDB_WIDTH-1:0][5:0]           cdb_pr;
  logic [RETIRE_WIDTH-1:0]             rt_valid;
  logic [RETIRE_WIDTH-1:0][4:0]        rt_rd;
  logic [RETIRE_WIDTH-1:0][5:0]        rt_pr;
  MAP_T                                arch_map_out;

  always #5 clk = ~clk;

  rename_map_table dut (
    .clk(clk), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd), .rn_new_pr(rn_new_pr),
    .rn_rs1_pr(rn_rs1_pr), .rn_rs2_pr(rn_rs2_pr), .rn_old_pr(rn_old_pr),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .rt_valid(rt_valid), .rt_rd(rt_rd), .rt_pr(rt_pr),
    .arch_map_out(arch_map_out)
  );

  int    checks = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  ment_t m_spec[ARCH_REGS];
  ment_t m_arch[ARCH_REGS];
  ment_t m_ckm[NUM_CKPT][ARCH_REGS];
  int    m_live[$];
  int    m_tail = 0;

  task automatic chk(string name, logic [255:0] got, logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] enc(ment_t m);
    return {6'(m.pr), m.rdy};
  endfunction

  function automatic bit cdb_any(int pr);
    for (int i = 0; i < CDB_WIDTH; i++)
      if (cdb_valid[i] && int'(cdb_pr[i]) == pr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ment_t mlook(int src, int k);
    ment_t r;
    if (src == 0) return '{0, 1'b1};
    for (int j = k - 1; j >= 0; j--)
      if (rn_valid[j] && int'(rn_rd[j]) == src) return '{int'(rn_new_pr[j]), 1'b0};
    r = m_spec[src];
    if (cdb_any(r.pr)) r.rdy = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    ment_t na[ARCH_REGS];
    ment_t ns[ARCH_REGS];
    bit    wr[ARCH_REGS];
    int    pre;
    int    p;
    na = m_arch;
    for (int r = 0; r < RETIRE_WIDTH; r++)
      if (rt_valid[r] && rt_rd[r] != 0) na[rt_rd[r]] = '{int'(rt_pr[r]), 1'b1};
    pre = m_live.size();
    for (int i = 0; i < NUM_CKPT; i++)
      for (int a = 0; a < ARCH_REGS; a++)
        if (cdb_any(m_ckm[i][a].pr)) m_ckm[i][a].rdy = 1'b1;
    if (flush) begin
      for (int a = 0; a < ARCH_REGS; a++) m_spec[a] = '{na[a].pr, 1'b1};
      m_live.delete();
      m_tail = 0;
    end else begin
      if (ckpt_restore) begin
        p = 0;
        foreach (m_live[i]) if (m_live[i] == int'(ckpt_restore_id)) p = i;
        for (int a = 0; a < ARCH_REGS; a++) m_spec[a] = m_ckm[ckpt_restore_id][a];
        while (m_live.size() > p + 1) void'(m_live.pop_back());
        m_tail = (int'(ckpt_restore_id) + 1) % NUM_CKPT;
      end else begin
        ns = m_spec;
        for (int a = 0; a < ARCH_REGS; a++) wr[a] = 1'b0;
        for (int k = 0; k < RENAME_WIDTH; k++)
          if (rn_valid[k] && rn_rd[k] != 0) begin
            ns[rn_rd[k]] = '{int'(rn_new_pr[k]), 1'b0};
            wr[rn_rd[k]] = 1'b1;
          end
        for (int a = 0; a < ARCH_REGS; a++)
          if (!wr[a] && cdb_any(ns[a].pr)) ns[a].rdy = 1'b1;
        m_spec = ns;
        if (ckpt_take && pre < NUM_CKPT) begin
          for (int a = 0; a < ARCH_REGS; a++) m_ckm[m_tail][a] = ns[a];
          m_live.push_back(m_tail);
          m_tail = (m_tail + 1) % NUM_CKPT;
        end
      end
      if (ckpt_release && pre > 0) void'(m_live.pop_front());
    end
    m_arch = na;
  endtask

  // Record what the DUT must show this cycle, then advance the model.
  task automatic issue();
    exp_t e;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      e.lk[0][k] = enc(mlook(int'(rn_rs1[k]), k));
      e.lk[1][k] = enc(mlook(int'(rn_rs2[k]), k));
      e.lk[2][k] = enc(mlook(int'(rn_rd[k]), k));
    end
    e.ckid = 2'(m_tail);
    e.full = (m_live.size() == NUM_CKPT);
    for (int a = 0; a < ARCH_REGS; a++) e.arch[a] = enc(m_arch[a]);
    exp_q.push_back(e);
    model_update();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rn_valid = '0; rn_rs1 = '0; rn_rs2 = '0; rn_rd = '0; rn_new_pr = '0;
    ckpt_take = 1'b0; ckpt_release = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
    flush = 1'b0; cdb_valid = '0; cdb_pr = '0; rt_valid = '0; rt_rd = '0; rt_pr = '0;
  endtask

  task automatic ren(int k, int rs1, int rs2, int rd, int pr);
    rn_valid[k] = 1'b1; rn_rs1[k] = 5'(rs1); rn_rs2[k] = 5'(rs2);
    rn_rd[k] = 5'(rd); rn_new_pr[k] = 6'(pr);
  endtask

  // Monitor: mid-cycle, compare DUT outputs against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < RENAME_WIDTH; k++) begin
          chk($sformatf("rs1_pr[%0d]", k), rn_rs1_pr[k], e.lk[0][k]);
          chk($sformatf("rs2_pr[%0d]", k), rn_rs2_pr[k], e.lk[1][k]);
          chk($sformatf("old_pr[%0d]", k), rn_old_pr[k], e.lk[2][k]);
        end
        chk("ckpt_id", ckpt_id, e.ckid);
        chk("ckpt_full", ckpt_full, e.full);
        chk("arch_map", arch_map_out, e.arch);
      end
    end
  end

  initial begin
    idle();
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_spec[i] = '{i, 1'b1};
      m_arch[i] = '{i, 1'b1};
    end
    for (int i = 0; i < NUM_CKPT; i++)
      for (int a = 0; a < ARCH_REGS; a++) m_ckm[i][a] = '{0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    rn_rs1[0] = 5; issue(); @(negedge clk);
    chk("reset_rs1", rn_rs1_pr[0], {6'd5, 1'b1});
    chk("reset_arch7", arch_map_out[7], {6'd7, 1'b1});
    advance();

    idle(); ren(0, 0, 0, 3, 40); ren(1, 3, 0, 3, 41); issue(); @(negedge clk);
    chk("bypass_rs1", rn_rs1_pr[1], {6'd40, 1'b0});
    chk("bypass_old", rn_old_pr[1], {6'd40, 1'b0});
    advance();
    idle(); rn_rs1[0] = 3; issue(); @(negedge clk);
    chk("bypass_map3", rn_rs1_pr[0], {6'd41, 1'b0});
    advance();

    idle(); ren(0, 0, 0, 4, 40); issue(); advance();
    idle(); cdb_valid[0] = 1'b1; cdb_pr[0] = 40; rn_rs2[0] = 4; issue(); @(negedge clk);
    chk("cdb_forward", rn_rs2_pr[0], {6'd40, 1'b1});
    advance();
    idle(); rn_rs2[0] = 4; issue(); @(negedge clk);
    chk("cdb_map4", rn_rs2_pr[0], {6'd40, 1'b1});
    advance();

    idle(); ckpt_take = 1'b1; issue(); @(negedge clk);
    chk("take_id0", ckpt_id, 0);
    advance();
    idle(); ren(0, 0, 0, 3, 50); issue(); advance();
    idle(); cdb_valid[0] = 1'b1; cdb_pr[0] = 41; issue(); advance();
    idle(); ckpt_restore = 1'b1; ckpt_restore_id = 0; issue(); advance();
    idle(); rn_rs1[0] = 3; issue(); @(negedge clk);
    chk("restore_map3", rn_rs1_pr[0], {6'd41, 1'b1});
    advance();

    idle(); flush = 1'b1; issue(); advance();
    for (int i = 0; i < 5; i++) begin
      idle(); ckpt_take = 1'b1; issue(); advance();
    end
    idle(); issue(); @(negedge clk);
    chk("fill_full", ckpt_full, 1);
    chk("fill_id_wrap", ckpt_id, 0);
    advance();
    idle(); ckpt_restore = 1'b1; ckpt_restore_id = 1; issue(); advance();
    idle(); issue(); @(negedge clk);
    chk("restore_next_id", ckpt_id, 2);
    chk("restore_not_full", ckpt_full, 0);
    advance();

    idle(); flush = 1'b1; rt_valid[0] = 1'b1; rt_rd[0] = 6; rt_pr[0] = 33; issue(); advance();
    idle(); rn_rs1[0] = 6; issue(); @(negedge clk);
    chk("flush_map6", rn_rs1_pr[0], {6'd33, 1'b1});
    chk("flush_arch6", arch_map_out[6], {6'd33, 1'b1});
    chk("flush_ckpt_id", ckpt_id, 0);
    chk("flush_not_full", ckpt_full, 0);
    advance();
    idle(); ren(0, 0, 0, 0, 12); issue(); advance();
    idle(); rn_rs1[0] = 0; issue(); @(negedge clk);
    chk("zero_rs1", rn_rs1_pr[0], {6'd0, 1'b1});
    chk("zero_arch0", arch_map_out[0], {6'd0, 1'b1});
    advance();

    for (int c = 0; c < 1500; c++) begin
      idle();
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        rn_valid[k]  = ($urandom_range(0, 9) < 7);
        rn_rs1[k]    = 5'($urandom_range(0, 7));
        rn_rs2[k]    = 5'($urandom_range(0, 7));
        rn_rd[k]     = 5'($urandom_range(0, 7));
        rn_new_pr[k] = 6'($urandom);
      end
      for (int i = 0; i < CDB_WIDTH; i++) begin
        cdb_valid[i] = 1'($urandom_range(0, 1));
        cdb_pr[i] = ($urandom_range(0, 1) == 1) ? 6'(m_spec[$urandom_range(0, 7)].pr)
                                                : 6'($urandom);
      end
      for (int r = 0; r < RETIRE_WIDTH; r++) begin
        rt_valid[r] = 1'($urandom_range(0, 1));
        rt_rd[r]    = 5'($urandom_range(0, 7));
        rt_pr[r]    = 6'($urandom);
      end
      ckpt_take    = ($urandom_range(0, 9) < 3);
      ckpt_release = ($urandom_range(0, 9) < 2);
      if (m_live.size() > 0 && $urandom_range(0, 99) < 8) begin
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'(m_live[$urandom_range(0, m_live.size() - 1)]);
      end
      flush = ($urandom_range(0, 99) < 3);
      issue();
      advance();
    end

    idle();
    repeat (3) advance();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
